io_mem_requester: RTL and testbench

Bus-initiator end of the system-bus memory protocol: it accepts read and write requests from a client, buffers them in a small FIFO, and drives the `n2m_request_*` side of the bus towards a memory or I/O responder. It tracks one outstanding read at a time, accepts the `m2n_response_*` beat, and returns read data to the client through a single-entry response register. A timeout converts a lost read response into an error response so the client never hangs. The block sits between a core-side I/O port and a responder such as the dummy I/O device memory.

---
 rtl/io_mem_requester.sv | 153 +++++++++++++++
 tb/tb_io_mem_requester.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mem_requester.sv
// io_mem_requester: client request FIFO feeding a bus initiator
// with one outstanding read, a response register and a read timeout.
module io_mem_requester #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 512,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [BUS_WIDTH-1:0]     req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] rsp_address,
  output logic [BUS_WIDTH-1:0]     rsp_data,
  output logic                     rsp_error,
  input  logic                     m2n_request_available,
  output logic [ADDRESS_WIDTH-1:0] n2m_request_address,
  output logic [BUS_WIDTH-1:0]     n2m_request_data,
  output logic                     n2m_request_read,
  output logic                     n2m_request_write,
  output logic                     mc_avail_o,
  input  logic                     m2n_response_valid,
  input  logic [ADDRESS_WIDTH-1:0] m2n_response_address,
  input  logic [BUS_WIDTH-1:0]     m2n_response_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic { IDLE, WAIT_RSP } state_e;

  logic                     fw_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fa_q [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]     fd_q [FIFO_DEPTH];
  logic [PW-1:0]            wp_q, rp_q;
  logic [PW:0]              cnt_q;

  state_e                   state_q;
  logic [CW-1:0]            tmo_q;
  logic                     req_rd_q, req_wr_q;
  logic [ADDRESS_WIDTH-1:0] bus_addr_q;
  logic [BUS_WIDTH-1:0]     bus_data_q;
  logic                     rsp_valid_q, rsp_err_q;
  logic [ADDRESS_WIDTH-1:0] rsp_addr_q;
  logic [BUS_WIDTH-1:0]     rsp_data_q;

  logic full, empty, push, pop;
  logic avail, accept;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign push   = req_valid & ~full;
  assign pop    = (state_q == IDLE) & ~empty
                & m2n_request_available;
  assign avail  = (state_q == WAIT_RSP) & ~rsp_valid_q;
  assign accept = m2n_response_valid & avail;

  assign req_ready           = ~full;
  assign mc_avail_o          = avail;
  assign n2m_request_read    = req_rd_q;
  assign n2m_request_write   = req_wr_q;
  assign n2m_request_address = bus_addr_q;
  assign n2m_request_data    = bus_data_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_error           = rsp_err_q;
  assign rsp_address         = rsp_addr_q;
  assign rsp_data            = rsp_data_q;

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fw_q[wp_q] <= req_write;
      fa_q[wp_q] <= req_address;
      fd_q[wp_q] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            bus_addr_q <= fa_q[rp_q];
            bus_data_q <= fd_q[rp_q];
            if (fw_q[rp_q]) begin
              req_wr_q <= 1'b1;
            end else begin
              req_rd_q <= 1'b1;
              tmo_q    <= '0;
              state_q  <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // A beat on the timeout cycle takes priority over the error.
          if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_addr_q  <= m2n_response_address;
            rsp_data_q  <= m2n_response_data;
            state_q     <= IDLE;
          end else if (avail) begin
            if (tmo_q == TMO_LAST) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_addr_q  <= bus_addr_q;
              rsp_data_q  <= '0;
              state_q     <= IDLE;
            end else begin
              tmo_q <= tmo_q + CW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_io_mem_requester.sv
// Directed bench for io_mem_requester: reads, posted writes,
// FIFO full, timeout, response backpressure and mid-read reset.
module tb_io_mem_requester;
  localparam int AW = 32;
  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [BW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [AW-1:0] rsp_address;
  logic [BW-1:0] rsp_data;
  logic          m2n_request_available;
  logic [AW-1:0] n2m_request_address;
  logic [BW-1:0] n2m_request_data;
  logic          n2m_request_read, n2m_request_write;
  logic          mc_avail_o;
  logic          m2n_response_valid;
  logic [AW-1:0] m2n_response_address;
  logic [BW-1:0] m2n_response_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [BW-1:0] exp_d;
  logic [AW-1:0] exp_a;

  io_mem_requester #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_address          (req_address),
    .req_data             (req_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_address          (rsp_address),
    .rsp_data             (rsp_data),
    .rsp_error            (rsp_error),
    .m2n_request_available(m2n_request_available),
    .n2m_request_address  (n2m_request_address),
    .n2m_request_data     (n2m_request_data),
    .n2m_request_read     (n2m_request_read),
    .n2m_request_write    (n2m_request_write),
    .mc_avail_o           (mc_avail_o),
    .m2n_response_valid   (m2n_response_valid),
    .m2n_response_address (m2n_response_address),
    .m2n_response_data    (m2n_response_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mkd(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic chk(input string tag,
                     input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [AW-1:0] a,
                      input logic [BW-1:0] d);
    m2n_response_valid   = 1'b1;
    m2n_response_address = a;
    m2n_response_data    = d;
  endtask

  task automatic push_req(input logic w,
                          input logic [AW-1:0] a,
                          input logic [BW-1:0] d);
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_data    = d;
  endtask

  initial begin
    reset                 = 1'b1;
    req_valid             = 1'b0;
    req_write             = 1'b0;
    req_address           = '0;
    req_data              = '0;
    rsp_ready             = 1'b0;
    m2n_request_available = 1'b0;
    m2n_response_valid    = 1'b0;
    m2n_response_address  = '0;
    m2n_response_data     = '0;
    tick();
    tick();
    chk("rst_req_ready", BW'(req_ready), BW'(1));
    chk("rst_rd", BW'(n2m_request_read), '0);
    chk("rst_wr", BW'(n2m_request_write), '0);
    chk("rst_avail", BW'(mc_avail_o), '0);
    chk("rst_rsp_valid", BW'(rsp_valid), '0);
    chk("rst_rsp_err", BW'(rsp_error), '0);
    chk("rst_rsp_addr", BW'(rsp_address), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_bus_addr", BW'(n2m_request_address), '0);
    chk("rst_bus_data", n2m_request_data, '0);
    reset = 1'b0;
    tick();

    // Single read of 0x40, answered two cycles after the strobe
    m2n_request_available = 1'b1;
    push_req(1'b0, 32'h40, '0);
    tick();
    req_valid = 1'b0;
    chk("t1_no_early_rd", BW'(n2m_request_read), '0);
    tick();
    chk("t1_rd_strobe", BW'(n2m_request_read), BW'(1));
    chk("t1_rd_addr", BW'(n2m_request_address), BW'(32'h40));
    chk("t1_avail", BW'(mc_avail_o), BW'(1));
    tick();
    chk("t1_rd_pulse_end", BW'(n2m_request_read), '0);
    exp_d = mkd(32'hA5A5_0001);
    beat(32'h40, exp_d);
    tick();
    m2n_response_valid = 1'b0;
    chk("t1_rsp_valid", BW'(rsp_valid), BW'(1));
    chk("t1_rsp_data", rsp_data, exp_d);
    chk("t1_rsp_err", BW'(rsp_error), '0);
    chk("t1_rsp_addr", BW'(rsp_address), BW'(32'h40));
    chk("t1_avail_off", BW'(mc_avail_o), '0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_clr", BW'(rsp_valid), '0);

    // Four back-to-back posted writes
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, AW'(i * 32'h40), mkd(32'h1000_0000 + i));
      tick();
      chk("t2_req_ready", BW'(req_ready), BW'(1));
      if (i > 0) begin
        chk("t2_wr", BW'(n2m_request_write), BW'(1));
        chk("t2_wr_addr", BW'(n2m_request_address),
            BW'((i - 1) * 32'h40));
        chk("t2_wr_data", n2m_request_data,
            mkd(32'h1000_0000 + i - 1));
      end
    end
    req_valid = 1'b0;
    tick();
    chk("t2_wr_last", BW'(n2m_request_write), BW'(1));
    chk("t2_wr_last_addr", BW'(n2m_request_address), BW'(32'hC0));
    chk("t2_wr_last_data", n2m_request_data, mkd(32'h1000_0003));
    tick();
    chk("t2_wr_done", BW'(n2m_request_write), '0);
    chk("t2_no_rsp", BW'(rsp_valid), '0);

    // Five reads while the responder is busy
    m2n_request_available = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, AW'(32'h100 + i * 32'h40), '0);
      tick();
      chk("t3_ready_fill", BW'(req_ready), BW'(i < 3));
      chk("t3_no_rd", BW'(n2m_request_read), '0);
    end
    push_req(1'b0, 32'h200, '0);
    tick();
    chk("t3_full_hold", BW'(req_ready), '0);
    chk("t3_no_rd_full", BW'(n2m_request_read), '0);
    m2n_request_available = 1'b1;
    tick();
    chk("t3_pop_ready", BW'(req_ready), BW'(1));
    for (int k = 0; k < 5; k++) begin
      exp_a = AW'(32'h100 + k * 32'h40);
      exp_d = mkd(32'hB000_0000 + k);
      chk("t3_rd", BW'(n2m_request_read), BW'(1));
      chk("t3_rd_addr", BW'(n2m_request_address), BW'(exp_a));
      tick();
      if (k == 0) begin
        req_valid = 1'b0;
        chk("t3_fifth_in", BW'(req_ready), '0);
      end
      chk("t3_one_out", BW'(n2m_request_read), '0);
      beat(exp_a, exp_d);
      tick();
      m2n_response_valid = 1'b0;
      chk("t3_rsp_valid", BW'(rsp_valid), BW'(1));
      chk("t3_rsp_data", rsp_data, exp_d);
      chk("t3_rsp_addr", BW'(rsp_address), BW'(exp_a));
      chk("t3_no_rd_rsp", BW'(n2m_request_read), '0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t3_rsp_clr", BW'(rsp_valid), '0);
      if (k == 4)
        chk("t3_drained", BW'(n2m_request_read), '0);
    end

    // Read with no response times out after 8 WAIT_RSP cycles
    push_req(1'b0, 32'h300, '0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("t4_rd", BW'(n2m_request_read), BW'(1));
    repeat (7) tick();
    chk("t4_not_yet", BW'(rsp_valid), '0);
    chk("t4_avail", BW'(mc_avail_o), BW'(1));
    tick();
    chk("t4_tmo_valid", BW'(rsp_valid), BW'(1));
    chk("t4_tmo_err", BW'(rsp_error), BW'(1));
    chk("t4_tmo_data", rsp_data, '0);
    chk("t4_tmo_addr", BW'(rsp_address), BW'(32'h300));
    chk("t4_avail_off", BW'(mc_avail_o), '0);
    beat(32'h999, mkd(32'hDEAD_BEEF));
    tick();
    m2n_response_valid = 1'b0;
    chk("t4_late_data", rsp_data, '0);
    chk("t4_late_err", BW'(rsp_error), BW'(1));
    chk("t4_late_addr", BW'(rsp_address), BW'(32'h300));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Second read outstanding while the response register is full
    push_req(1'b0, 32'h400, '0);
    tick();
    push_req(1'b0, 32'h440, '0);
    tick();
    req_valid = 1'b0;
    chk("t5_rd0_addr", BW'(n2m_request_address), BW'(32'h400));
    beat(32'h400, mkd(32'hC000_0000));
    tick();
    m2n_response_valid = 1'b0;
    chk("t5_rsp0", rsp_data, mkd(32'hC000_0000));
    tick();
    chk("t5_rd1", BW'(n2m_request_read), BW'(1));
    chk("t5_rd1_addr", BW'(n2m_request_address), BW'(32'h440));
    chk("t5_avail_blk", BW'(mc_avail_o), '0);
    beat(32'h440, mkd(32'hC000_0002));
    repeat (12) tick();
    m2n_response_valid = 1'b0;
    chk("t5_hold_avail", BW'(mc_avail_o), '0);
    chk("t5_hold_valid", BW'(rsp_valid), BW'(1));
    chk("t5_hold_data", rsp_data, mkd(32'hC000_0000));
    chk("t5_hold_err", BW'(rsp_error), '0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t5_released", BW'(rsp_valid), '0);
    chk("t5_avail_on", BW'(mc_avail_o), BW'(1));
    repeat (5) tick();
    chk("t5_frozen", BW'(rsp_valid), '0);
    beat(32'h440, mkd(32'hC000_0001));
    tick();
    m2n_response_valid = 1'b0;
    chk("t5_rsp1_valid", BW'(rsp_valid), BW'(1));
    chk("t5_rsp1_err", BW'(rsp_error), '0);
    chk("t5_rsp1_data", rsp_data, mkd(32'hC000_0001));
    chk("t5_rsp1_addr", BW'(rsp_address), BW'(32'h440));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Beat on the timeout cycle wins over the error
    push_req(1'b0, 32'h500, '0);
    tick();
    req_valid = 1'b0;
    tick();
    repeat (7) tick();
    chk("t6_not_yet", BW'(rsp_valid), '0);
    beat(32'h500, mkd(32'hE000_0005));
    tick();
    m2n_response_valid = 1'b0;
    chk("t6_valid", BW'(rsp_valid), BW'(1));
    chk("t6_err", BW'(rsp_error), '0);
    chk("t6_data", rsp_data, mkd(32'hE000_0005));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while a read is outstanding and a write is queued
    push_req(1'b0, 32'h600, '0);
    tick();
    push_req(1'b1, 32'h640, mkd(32'hF000_0000));
    tick();
    req_valid = 1'b0;
    chk("t7_rd", BW'(n2m_request_read), BW'(1));
    reset = 1'b1;
    #1;
    chk("t7_rst_avail", BW'(mc_avail_o), '0);
    chk("t7_rst_ready", BW'(req_ready), BW'(1));
    chk("t7_rst_addr", BW'(n2m_request_address), '0);
    tick();
    reset = 1'b0;
    beat(32'h600, mkd(32'h7777_7777));
    tick();
    m2n_response_valid = 1'b0;
    chk("t7_late_drop", BW'(rsp_valid), '0);
    chk("t7_flushed_wr", BW'(n2m_request_write), '0);
    tick();
    chk("t7_flushed_wr2", BW'(n2m_request_write), '0);
    chk("t7_idle_avail", BW'(mc_avail_o), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
